// File: rtl/fetch_pkg.sv
// Shared definitions for the byte-serial command fetch stage: state encoding,
// bus widths and the decoder size-to-length mapping.
package fetch_pkg;

    localparam int BYTE_W        = 8;
    localparam int MAX_CMD_BYTES = 3;
    localparam int CMD_BUS_W     = BYTE_W * MAX_CMD_BYTES;
    localparam int CMD_FLG_W     = 6;

    localparam logic [2:0] S_OP_REQ   = 3'd0;
    localparam logic [2:0] S_OP_WAIT  = 3'd1;
    localparam logic [2:0] S_SIZE     = 3'd2;
    localparam logic [2:0] S_ARG_WAIT = 3'd3;
    localparam logic [2:0] S_OUT      = 3'd4;

    // An opcode the decoder does not recognise (size 0) is emitted as a
    // single-byte command so the stream keeps moving.
    function automatic logic [1:0] cmdLen(input logic [1:0] decSize);
        return (decSize == 2'd0) ? 2'd1 : decSize;
    endfunction

endpackage

// File: rtl/cmd_fetch_if.sv
// Bundle of memory, decoder, execute-stage and redirect signals around the
// fetch stage; names carry _i/_o from the fetch stage's point of view.
interface cmd_fetch_if #(
    parameter int PC_W = 8
);
    import fetch_pkg::*;

    logic                  mem_rd_o;
    logic [PC_W-1:0]       mem_addr_o;
    logic [BYTE_W-1:0]     mem_data_i;
    logic [BYTE_W-1:0]     cmd_code_o;
    logic [1:0]            dec_size_i;
    logic [CMD_FLG_W-1:0]  dec_flgs_i;
    logic                  cmd_valid_o;
    logic                  cmd_ready_i;
    logic [CMD_BUS_W-1:0]  cmd_bytes_o;
    logic [1:0]            cmd_len_o;
    logic [CMD_FLG_W-1:0]  cmd_flgs_o;
    logic [PC_W-1:0]       cmd_pc_o;
    logic                  cmd_ill_o;
    logic                  jmp_valid_i;
    logic [PC_W-1:0]       jmp_addr_i;

    modport master (
        output mem_rd_o, mem_addr_o, cmd_code_o, cmd_valid_o, cmd_bytes_o,
               cmd_len_o, cmd_flgs_o, cmd_pc_o, cmd_ill_o,
        input  mem_data_i, dec_size_i, dec_flgs_i, cmd_ready_i,
               jmp_valid_i, jmp_addr_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o, cmd_code_o, cmd_valid_o, cmd_bytes_o,
               cmd_len_o, cmd_flgs_o, cmd_pc_o, cmd_ill_o,
        output mem_data_i, dec_size_i, dec_flgs_i, cmd_ready_i,
               jmp_valid_i, jmp_addr_i
    );

endinterface

// File: rtl/cmd_fetch.sv
// Byte-serial command fetch: reads the opcode, asks the external decoder for
// its size, gathers operand bytes and hands one command per handshake.
module cmd_fetch
    import fetch_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    cmd_fetch_if.master bus
);

    logic [2:0]           state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      cmdPc_q, cmdPc_d;
    logic [CMD_BUS_W-1:0] bytes_q, bytes_d;
    logic [1:0]           len_q, len_d;
    logic [1:0]           rem_q, rem_d;
    logic [CMD_FLG_W-1:0] flgs_q, flgs_d;
    logic                 ill_q, ill_d;
    logic [BYTE_W-1:0]    code_q, code_d;

    logic                 rd;
    logic [PC_W-1:0]      rdAddr;
    logic                 handshake;
    logic [1:0]           argIdx;

    assign handshake = (state_q == S_OUT) && bus.cmd_ready_i;
    assign argIdx    = len_q - rem_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cmdPc_d = cmdPc_q;
        bytes_d = bytes_q;
        len_d   = len_q;
        rem_d   = rem_q;
        flgs_d  = flgs_q;
        ill_d   = ill_q;
        code_d  = code_q;
        rd      = 1'b0;
        rdAddr  = pc_q;

        case (state_q)
            S_OP_REQ: begin
                rd      = 1'b1;
                state_d = S_OP_WAIT;
            end
            S_OP_WAIT: begin
                code_d  = bus.mem_data_i;
                bytes_d = {{(CMD_BUS_W-BYTE_W){1'b0}}, bus.mem_data_i};
                cmdPc_d = pc_q;
                state_d = S_SIZE;
            end
            S_SIZE: begin
                flgs_d = bus.dec_flgs_i;
                ill_d  = (bus.dec_size_i == 2'd0);
                len_d  = cmdLen(bus.dec_size_i);
                if (len_d == 2'd1) begin
                    state_d = S_OUT;
                end else begin
                    rd      = 1'b1;
                    rdAddr  = pc_q + PC_W'(1);
                    rem_d   = len_d - 2'd1;
                    state_d = S_ARG_WAIT;
                end
            end
            S_ARG_WAIT: begin
                case (argIdx)
                    2'd1:    bytes_d[2*BYTE_W-1:BYTE_W]   = bus.mem_data_i;
                    2'd2:    bytes_d[3*BYTE_W-1:2*BYTE_W] = bus.mem_data_i;
                    default: bytes_d = bytes_q;
                endcase
                if (rem_q > 2'd1) begin
                    rd     = 1'b1;
                    rdAddr = pc_q + PC_W'(2);
                    rem_d  = rem_q - 2'd1;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (handshake) begin
                    pc_d    = pc_q + PC_W'(len_q);
                    rd      = 1'b1;
                    rdAddr  = pc_d;
                    state_d = S_OP_WAIT;
                end
            end
            default: state_d = S_OP_REQ;
        endcase

        // A redirect wins over everything, including a same-cycle handshake;
        // the read is suppressed so nothing stale is left in flight.
        if (bus.jmp_valid_i) begin
            state_d = S_OP_REQ;
            pc_d    = bus.jmp_addr_i;
            rd      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_OP_REQ;
            pc_q    <= RESET_PC;
            cmdPc_q <= '0;
            bytes_q <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            flgs_q  <= '0;
            ill_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmdPc_q <= cmdPc_d;
            bytes_q <= bytes_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            flgs_q  <= flgs_d;
            ill_q   <= ill_d;
            code_q  <= code_d;
        end
    end

    // The reset state already requests a fetch, so the strobe is gated while
    // reset is held to keep every output at zero.
    assign bus.mem_rd_o    = rd & rst_n_i;
    assign bus.mem_addr_o  = (rd & rst_n_i) ? rdAddr : '0;
    assign bus.cmd_code_o  = code_q;
    assign bus.cmd_valid_o = (state_q == S_OUT);
    assign bus.cmd_bytes_o = bytes_q;
    assign bus.cmd_len_o   = len_q;
    assign bus.cmd_flgs_o  = flgs_q;
    assign bus.cmd_pc_o    = cmdPc_q;
    assign bus.cmd_ill_o   = ill_q;

endmodule

// File: tb/tb_cmd_fetch.sv
// Directed bench for cmd_fetch: byte-wide memory and opcode decoder models,
// one task per scenario with hand-computed expectations.
module tb_cmd_fetch;
    import fetch_pkg::*;

    localparam int PC_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   passes   = 0;
    int   protoErr = 0;

    always #5 clk = ~clk;

    cmd_fetch_if #(.PC_W(PC_W)) bus ();

    cmd_fetch #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Program memory with one cycle read latency
    logic [7:0] mem [0:255];
    logic [7:0] memData = 8'h00;

    always @(posedge clk) begin
        if (bus.mem_rd_o === 1'b1) memData <= mem[bus.mem_addr_o];
    end
    assign bus.mem_data_i = memData;

    // Opcode decoder: ADD 0x41 (1 byte), JMP 0x4A (2), MOV 0x4D (3), else unknown
    logic [1:0] decSize;
    logic [5:0] decFlgs;
    always_comb begin
        decSize = 2'd0;
        decFlgs = 6'b000000;
        case (bus.cmd_code_o)
            8'h41: begin decSize = 2'd1; decFlgs = 6'b010000; end
            8'h4A: begin decSize = 2'd2; decFlgs = 6'b001000; end
            8'h4D: begin decSize = 2'd3; decFlgs = 6'b000100; end
            default: begin decSize = 2'd0; decFlgs = 6'b000000; end
        endcase
    end
    assign bus.dec_size_i = decSize;
    assign bus.dec_flgs_i = decFlgs;

    // No read may be issued while a command waits unaccepted
    always @(posedge clk) begin
        if (rst_n && bus.cmd_valid_o && bus.mem_rd_o && !bus.cmd_ready_i)
            protoErr++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic startDut();
        bus.jmp_valid_i = 1'b0;
        bus.jmp_addr_i  = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitValid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.cmd_valid_o !== 1'b1 && cyc < 40);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_valid_o, bus.mem_rd_o, bus.mem_addr_o} !== 10'd0)
            $display("[TB] FAIL reset_strobe got %h want 0", {bus.cmd_valid_o, bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
        checks++;
        if ({bus.cmd_bytes_o, bus.cmd_code_o} !== 32'd0)
            $display("[TB] FAIL reset_bytes got %h want 0", {bus.cmd_bytes_o, bus.cmd_code_o});
        else passes++;
        checks++;
        if ({bus.cmd_len_o, bus.cmd_flgs_o, bus.cmd_pc_o, bus.cmd_ill_o} !== 17'd0)
            $display("[TB] FAIL reset_meta got %h want 0", {bus.cmd_len_o, bus.cmd_flgs_o, bus.cmd_pc_o, bus.cmd_ill_o});
        else passes++;
    endtask

    task automatic test_add();
        int c;
        clearMem();
        mem[0] = 8'h41; mem[1] = 8'h41;
        bus.cmd_ready_i = 1'b1;
        startDut();
        waitValid(c);
        checks++;
        if (c != 3) $display("[TB] FAIL add_latency got %0d want 3", c); else passes++;
        checks++;
        if (bus.cmd_bytes_o !== 24'h000041) $display("[TB] FAIL add_bytes got %h want 000041", bus.cmd_bytes_o); else passes++;
        checks++;
        if ({bus.cmd_len_o, bus.cmd_flgs_o, bus.cmd_pc_o} !== {2'd1, 6'b010000, 8'h00})
            $display("[TB] FAIL add_meta got %h want %h", {bus.cmd_len_o, bus.cmd_flgs_o, bus.cmd_pc_o}, {2'd1, 6'b010000, 8'h00});
        else passes++;
        checks++;
        if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 8'h01})
            $display("[TB] FAIL add_next_read got %h want 101", {bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
    endtask

    task automatic test_mov();
        int c;
        clearMem();
        mem[0] = 8'h4D; mem[1] = 8'h05; mem[2] = 8'h07; mem[3] = 8'h41;
        bus.cmd_ready_i = 1'b1;
        startDut();
        waitValid(c);
        checks++;
        if (c != 5) $display("[TB] FAIL mov_latency got %0d want 5", c); else passes++;
        checks++;
        if ({bus.cmd_bytes_o, bus.cmd_len_o, bus.cmd_flgs_o} !== {24'h07054D, 2'd3, 6'b000100})
            $display("[TB] FAIL mov_cmd got %h/%0d/%b want 07054d/3/000100", bus.cmd_bytes_o, bus.cmd_len_o, bus.cmd_flgs_o);
        else passes++;
        checks++;
        if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 8'h03})
            $display("[TB] FAIL mov_next_read got %h want 103", {bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
    endtask

    task automatic test_back_to_back();
        int c;
        clearMem();
        mem[0] = 8'h41; mem[1] = 8'h4A; mem[2] = 8'h10; mem[3] = 8'h41;
        bus.cmd_ready_i = 1'b1;
        startDut();
        waitValid(c);
        @(negedge clk);
        bus.cmd_ready_i = 1'b0;
        waitValid(c);
        checks++;
        if (c != 3) $display("[TB] FAIL b2b_jmp_latency got %0d want 3", c); else passes++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus.cmd_valid_o, bus.mem_rd_o, bus.cmd_bytes_o, bus.cmd_len_o, bus.cmd_pc_o} !==
                {1'b1, 1'b0, 24'h00104A, 2'd2, 8'h01})
                $display("[TB] FAIL stall_hold_%0d got v%b r%b %h len%0d pc%h want v1 r0 00104a len2 pc01",
                         k, bus.cmd_valid_o, bus.mem_rd_o, bus.cmd_bytes_o, bus.cmd_len_o, bus.cmd_pc_o);
            else passes++;
            @(negedge clk);
        end
        bus.cmd_ready_i = 1'b1;
        #1;
        checks++;
        if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 8'h03})
            $display("[TB] FAIL stall_release_read got %h want 103", {bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
        waitValid(c);
        checks++;
        if ({bus.cmd_pc_o, bus.cmd_bytes_o} !== {8'h03, 24'h000041} || c != 3)
            $display("[TB] FAIL b2b_next got pc%h %h after %0d want pc03 000041 after 3", bus.cmd_pc_o, bus.cmd_bytes_o, c);
        else passes++;
    endtask

    task automatic test_redirect();
        int c;
        clearMem();
        mem[0] = 8'h4D; mem[1] = 8'h05; mem[2] = 8'h07; mem[8'h20] = 8'h41;
        bus.cmd_ready_i = 1'b1;
        startDut();
        repeat (3) @(negedge clk);
        bus.jmp_valid_i = 1'b1;
        bus.jmp_addr_i  = 8'h20;
        @(negedge clk);
        bus.jmp_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_valid_o, bus.mem_rd_o, bus.mem_addr_o} !== {1'b0, 1'b1, 8'h20})
            $display("[TB] FAIL jmp_read got %h want 120", {bus.cmd_valid_o, bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
        waitValid(c);
        checks++;
        if (c != 3) $display("[TB] FAIL jmp_latency got %0d want 3", c); else passes++;
        checks++;
        if ({bus.cmd_pc_o, bus.cmd_bytes_o, bus.cmd_len_o} !== {8'h20, 24'h000041, 2'd1})
            $display("[TB] FAIL jmp_cmd got pc%h %h len%0d want pc20 000041 len1", bus.cmd_pc_o, bus.cmd_bytes_o, bus.cmd_len_o);
        else passes++;
    endtask

    task automatic test_wrap();
        int c;
        clearMem();
        mem[8'hFE] = 8'h4D; mem[8'hFF] = 8'h05; mem[0] = 8'h07; mem[1] = 8'h41;
        bus.cmd_ready_i = 1'b1;
        startDut();
        bus.jmp_valid_i = 1'b1;
        bus.jmp_addr_i  = 8'hFE;
        @(negedge clk);
        bus.jmp_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 8'hFE})
            $display("[TB] FAIL wrap_rd0 got %h want 1fe", {bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 8'hFF})
            $display("[TB] FAIL wrap_rd1 got %h want 1ff", {bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.mem_rd_o, bus.mem_addr_o} !== {1'b1, 8'h00})
            $display("[TB] FAIL wrap_rd2 got %h want 100", {bus.mem_rd_o, bus.mem_addr_o});
        else passes++;
        waitValid(c);
        checks++;
        if ({bus.cmd_pc_o, bus.cmd_bytes_o, bus.mem_addr_o} !== {8'hFE, 24'h07054D, 8'h01} || c != 2)
            $display("[TB] FAIL wrap_cmd got pc%h %h next%h after %0d want pcfe 07054d next01 after 2",
                     bus.cmd_pc_o, bus.cmd_bytes_o, bus.mem_addr_o, c);
        else passes++;
        waitValid(c);
        checks++;
        if ({bus.cmd_pc_o, bus.cmd_bytes_o} !== {8'h01, 24'h000041})
            $display("[TB] FAIL wrap_next got pc%h %h want pc01 000041", bus.cmd_pc_o, bus.cmd_bytes_o);
        else passes++;
    endtask

    task automatic test_illegal();
        int c;
        clearMem();
        mem[1] = 8'h41;
        bus.cmd_ready_i = 1'b1;
        startDut();
        waitValid(c);
        checks++;
        if ({bus.cmd_len_o, bus.cmd_ill_o, bus.cmd_bytes_o, bus.cmd_flgs_o} !== {2'd1, 1'b1, 24'h0, 6'b0} || c != 3)
            $display("[TB] FAIL ill_cmd got len%0d ill%b %h flg%b after %0d want len1 ill1 000000 flg000000 after 3",
                     bus.cmd_len_o, bus.cmd_ill_o, bus.cmd_bytes_o, bus.cmd_flgs_o, c);
        else passes++;
        waitValid(c);
        checks++;
        if ({bus.cmd_ill_o, bus.cmd_pc_o} !== {1'b0, 8'h01})
            $display("[TB] FAIL ill_clear got ill%b pc%h want ill0 pc01", bus.cmd_ill_o, bus.cmd_pc_o);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int c;
        clearMem();
        mem[0] = 8'h4D; mem[1] = 8'h05; mem[2] = 8'h07;
        bus.cmd_ready_i = 1'b1;
        startDut();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_valid_o, bus.mem_rd_o, bus.mem_addr_o, bus.cmd_code_o, bus.cmd_bytes_o,
             bus.cmd_len_o, bus.cmd_flgs_o, bus.cmd_pc_o, bus.cmd_ill_o} !== 59'd0)
            $display("[TB] FAIL midreset_zero got code%h len%0d flg%b rd%b want all zero",
                     bus.cmd_code_o, bus.cmd_len_o, bus.cmd_flgs_o, bus.mem_rd_o);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitValid(c);
        checks++;
        if ({bus.cmd_pc_o, bus.cmd_bytes_o} !== {8'h00, 24'h07054D} || c != 5)
            $display("[TB] FAIL midreset_restart got pc%h %h after %0d want pc00 07054d after 5",
                     bus.cmd_pc_o, bus.cmd_bytes_o, c);
        else passes++;
    endtask

    initial begin
        bus.cmd_ready_i = 1'b0;
        bus.jmp_valid_i = 1'b0;
        bus.jmp_addr_i  = 8'h00;
        clearMem();
        test_reset();
        test_add();
        test_mov();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_illegal();
        test_reset_mid();
        checks++;
        if (protoErr != 0) $display("[TB] FAIL read_while_stalled got %0d want 0", protoErr); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cmd_fetch.md
# cmd_fetch

Byte-serial command fetch stage for the lab CPU, directly upstream of the opcode decoder. Reads the byte-wide program memory, presents each opcode byte to the decoder, and uses the returned command size to collect 0–2 operand bytes. Emits one assembled command per valid/ready handshake to the execute stage. Accepts a jump redirect that flushes the command being assembled.

## Interface
- PC_W, 8, program counter / memory address width
- RESET_PC, 0, first fetch address after reset
- CLK_  in  1  clock, all state on rising edge
- RST_N_  in  1  reset; one clock, asynchronous and active-low
- MEM_RD_  out  1  memory read strobe; data returned exactly one cycle later
- MEM_ADDR_  out  PC_W  read address
- MEM_DATA_  in  8  read data, valid the cycle after MEM_RD_
- CMD_CODE_  out  8  registered opcode driven to the decoder
- DEC_SIZE_  in  2  decoder size result (1..3; 0 = unknown)
- DEC_FLGS_  in  6  decoder one-hot command flags
- CMD_VALID_  out  1  assembled command available
- CMD_READY_  in  1  execute stage accepts
- CMD_BYTES_  out  24  byte0 in [7:0], byte1 [15:8], byte2 [23:16]; unused bytes 0
- CMD_LEN_  out  2  command length in bytes (1..3)
- CMD_FLGS_  out  6  registered decoder flags
- CMD_PC_  out  PC_W  address of byte0
- CMD_ILL_  out  1  opcode decoded with size 0
- JMP_VALID_  in  1  redirect request, single-cycle pulse
- JMP_ADDR_  in  PC_W  redirect target

## Operation
- States: S_OP_REQ, S_OP_WAIT, S_SIZE, S_ARG_WAIT, S_OUT.
- Reset: state S_OP_REQ, PC=RESET_PC, all outputs 0 (CMD_VALID_=0, MEM_RD_=0, CMD_BYTES_=0, CMD_LEN_=0, CMD_FLGS_=0, CMD_PC_=0, CMD_ILL_=0, CMD_CODE_=0).
- S_OP_REQ: MEM_RD_=1, MEM_ADDR_=PC; -> S_OP_WAIT.
- S_OP_WAIT: capture MEM_DATA_ into byte0 and CMD_CODE_, clear bytes 1–2; -> S_SIZE.
- S_SIZE: sample DEC_SIZE_/DEC_FLGS_ (CMD_CODE_ is stable a full cycle). Length = DEC_SIZE_, or 1 with CMD_ILL_=1 if DEC_SIZE_=0. Length 1 -> S_OUT; else MEM_RD_=1 at PC+1, remaining=length-1, -> S_ARG_WAIT.
- S_ARG_WAIT: capture byte at index length-remaining; if remaining>1, issue next read (PC+2) in the same cycle and stay; else -> S_OUT.
- S_OUT: CMD_VALID_=1, all CMD_* outputs held stable until handshake. On CMD_VALID_&CMD_READY_: PC += CMD_LEN_, MEM_RD_=1 at the new PC in the same cycle, -> S_OP_WAIT.
- Address arithmetic modulo 2^PC_W; a command straddling the top address wraps to 0.
- Redirect (JMP_VALID_=1) in any state: highest priority; next cycle PC=JMP_ADDR_, state S_OP_REQ, CMD_VALID_=0, outstanding read data discarded. Redirect coincident with handshake: command counts as accepted, PC from JMP_ADDR_ (not PC+len).
- Reset assertion mid-command: immediate return to reset values; partial command lost.

## Timing
- From reset release (cycle 0 = S_OP_REQ): first CMD_VALID_ at cycle 2+length (ADD: 3, JMP: 4, MOV: 5).
- Back-to-back with CMD_READY_ held 1: next CMD_VALID_ (length+2) cycles after the handshake cycle.
- After redirect pulse in cycle t: MEM_RD_ at JMP_ADDR_ in t+1; CMD_VALID_ at t+3+length.
- At most one memory read outstanding; MEM_RD_ never asserted while CMD_VALID_=1 except on the handshake cycle.
- CMD_VALID_ never drops without handshake, redirect, or reset.

## Structure
- Shared package fetch_pkg: state encoding, BYTE_W=8, MAX_CMD_BYTES=3, CMD_BUS_W=24. Opcode codes stay in the existing shared defines.
- Single module; no sub-module. The decoder is instantiated beside it in the CPU top, not inside.

## Test plan
- Memory {0:0x41} (ADD), READY=1 -> after reset CMD_VALID_ at cycle 3, CMD_BYTES_=0x000041, LEN=1, FLGS=010000, PC=0.
- Memory {0:0x4D,1:0x05,2:0x07} (MOV) -> VALID at cycle 5, BYTES=0x07054D, LEN=3, next MEM_ADDR_=3.
- ADD, JMP 0x10, ADD with READY=0 for 4 cycles on the JMP -> outputs stable while stalled; after release PC advances 1→3, no byte lost.
- JMP_VALID_ pulse with JMP_ADDR_=0x20 during S_ARG_WAIT of a MOV -> no MOV emitted; next MEM_ADDR_=0x20; next command PC=0x20.
- PC_W=8, MOV at 0xFE -> bytes read from 0xFE,0xFF,0x00; next PC=0x01.
- Opcode 0x00 (size 0) -> LEN=1, CMD_ILL_=1; RST_N_ asserted mid-MOV -> all outputs 0 asynchronously, fetch restarts at RESET_PC.
